// File: rtl/cursor_tracker.sv
`default_nettype none
// ============================================================================
// Module   : cursor_tracker
// Purpose  : Saturating cursor integrator with click/drag FSM, right-click
//            detection and a one-entry valid/ready pointer-event register.
// Revision : 1.0 - initial release
// ============================================================================
module cursor_tracker #(
    parameter int POS_W       = 10,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_CENTER    = 320,
    parameter int Y_CENTER    = 240,
    parameter int DISP_W      = 8,
    parameter int DEADZONE    = 4,
    parameter int SHIFT       = 1,
    parameter int KEY_STEP    = 1,
    parameter int DRAG_THRESH = 3
) (
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [7:0]        keycode,
    input  logic [DISP_W-1:0] x_disp,
    input  logic [DISP_W-1:0] y_disp,
    input  logic [2:0]        buttons,
    output logic [POS_W-1:0]  MouseX,
    output logic [POS_W-1:0]  MouseY,
    output logic              dragging,
    output logic              evt_valid,
    output logic [1:0]        evt_type,
    output logic [POS_W-1:0]  evt_x,
    output logic [POS_W-1:0]  evt_y,
    input  logic              evt_ready,
    output logic              evt_overflow
);

    // Arithmetic width: POS_W+2, widened only if a displacement would not fit.
    localparam int MOT_W = (DISP_W + 1 > POS_W + 2) ? DISP_W + 1 : POS_W + 2;

    localparam logic [7:0] KEY_LEFT  = 8'h01;
    localparam logic [7:0] KEY_RIGHT = 8'h02;
    localparam logic [7:0] KEY_DOWN  = 8'h04;
    localparam logic [7:0] KEY_UP    = 8'h1A;

    localparam logic [1:0] EVT_CLICK = 2'd0;
    localparam logic [1:0] EVT_DROP  = 2'd1;
    localparam logic [1:0] EVT_RIGHT = 2'd2;

    localparam logic signed [MOT_W-1:0] MOT_STEP = MOT_W'(KEY_STEP);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        DRAG    = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Motion and saturation helpers
    // ------------------------------------------------------------------------
    function automatic logic signed [MOT_W-1:0] axis_motion(input logic [DISP_W-1:0] d);
        logic [DISP_W-1:0] mag;
        logic [MOT_W-1:0]  step;
        // The most-negative sample negates to itself, which read unsigned is 2^(DISP_W-1).
        mag  = d[DISP_W-1] ? (~d + DISP_W'(1)) : d;
        step = MOT_W'(mag >> SHIFT);
        if (int'(mag) <= DEADZONE) begin
            return '0;
        end
        return d[DISP_W-1] ? -$signed(step) : $signed(step);
    endfunction

    function automatic logic [POS_W-1:0] saturate(input logic signed [MOT_W-1:0] v,
                                                  input int                      lim);
        if (v[MOT_W-1]) begin
            return '0;
        end
        if (int'(v) > lim) begin
            return POS_W'(lim);
        end
        return v[POS_W-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------------
    state_t                   state;
    logic [1:0]               btn_prev;
    logic [POS_W-1:0]         press_x;
    logic [POS_W-1:0]         press_y;

    logic signed [MOT_W-1:0]  mot_x;
    logic signed [MOT_W-1:0]  mot_y;
    logic signed [MOT_W-1:0]  sum_x;
    logic signed [MOT_W-1:0]  sum_y;
    logic [POS_W-1:0]         next_x;
    logic [POS_W-1:0]         next_y;

    logic                     left_rise;
    logic                     left_fall;
    logic                     right_rise;
    logic [POS_W-1:0]         dist_x;
    logic [POS_W-1:0]         dist_y;
    logic                     beyond_thresh;

    logic                     left_evt;
    logic [1:0]               left_type;
    logic [POS_W-1:0]         left_x;
    logic [POS_W-1:0]         left_y;

    logic                     new_evt;
    logic [1:0]               new_type;
    logic [POS_W-1:0]         new_x;
    logic [POS_W-1:0]         new_y;
    logic                     lost_right;
    logic                     evt_load;
    logic                     evt_drop;

    logic                     unused_middle;

    assign unused_middle = buttons[2];

    // ------------------------------------------------------------------------
    // Position datapath
    // ------------------------------------------------------------------------
    always_comb begin
        mot_x = axis_motion(x_disp);
        mot_y = axis_motion(y_disp);
        case (keycode)
            KEY_LEFT: begin
                mot_x = -MOT_STEP;
                mot_y = '0;
            end
            KEY_RIGHT: begin
                mot_x = MOT_STEP;
                mot_y = '0;
            end
            KEY_DOWN: begin
                mot_x = '0;
                mot_y = MOT_STEP;
            end
            KEY_UP: begin
                mot_x = '0;
                mot_y = -MOT_STEP;
            end
            default: ;
        endcase
    end

    assign sum_x  = $signed(MOT_W'(MouseX)) + mot_x;
    assign sum_y  = $signed(MOT_W'(MouseY)) + mot_y;
    assign next_x = saturate(sum_x, X_MAX);
    assign next_y = saturate(sum_y, Y_MAX);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            MouseX   <= POS_W'(X_CENTER);
            MouseY   <= POS_W'(Y_CENTER);
            btn_prev <= 2'b00;
        end else begin
            MouseX   <= next_x;
            MouseY   <= next_y;
            btn_prev <= buttons[1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Button edges and drag distance (against registered position)
    // ------------------------------------------------------------------------
    assign left_rise  =  buttons[0] & ~btn_prev[0];
    assign left_fall  = ~buttons[0] &  btn_prev[0];
    assign right_rise =  buttons[1] & ~btn_prev[1];

    assign dist_x = (MouseX >= press_x) ? (MouseX - press_x) : (press_x - MouseX);
    assign dist_y = (MouseY >= press_y) ? (MouseY - press_y) : (press_y - MouseY);
    assign beyond_thresh = (int'(dist_x) > DRAG_THRESH) || (int'(dist_y) > DRAG_THRESH);

    // ------------------------------------------------------------------------
    // Left-button click/drag FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            dragging <= 1'b0;
            press_x  <= '0;
            press_y  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (left_rise) begin
                        state   <= PRESSED;
                        press_x <= MouseX;
                        press_y <= MouseY;
                    end
                end
                PRESSED: begin
                    // A release beats the drag test on the same edge.
                    if (left_fall) begin
                        state <= IDLE;
                    end else if (beyond_thresh) begin
                        state    <= DRAG;
                        dragging <= 1'b1;
                    end
                end
                DRAG: begin
                    if (left_fall) begin
                        state    <= IDLE;
                        dragging <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    dragging <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        left_evt  = 1'b0;
        left_type = EVT_CLICK;
        left_x    = press_x;
        left_y    = press_y;
        case (state)
            PRESSED: begin
                left_evt = left_fall;
            end
            DRAG: begin
                left_evt  = left_fall;
                left_type = EVT_DROP;
                left_x    = next_x;
                left_y    = next_y;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Event arbitration and one-entry event register
    // ------------------------------------------------------------------------
    assign new_evt    = left_evt | right_rise;
    assign new_type   = left_evt ? left_type : EVT_RIGHT;
    assign new_x      = left_evt ? left_x    : MouseX;
    assign new_y      = left_evt ? left_y    : MouseY;
    assign lost_right = left_evt & right_rise;
    assign evt_load   = new_evt & (~evt_valid | evt_ready);
    assign evt_drop   = new_evt & evt_valid & ~evt_ready;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            evt_valid    <= 1'b0;
            evt_type     <= EVT_CLICK;
            evt_x        <= '0;
            evt_y        <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (evt_load) begin
                evt_valid <= 1'b1;
                evt_type  <= new_type;
                evt_x     <= new_x;
                evt_y     <= new_y;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (evt_drop || lost_right) begin
                evt_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cursor_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_cursor_tracker
// Purpose  : Scoreboard bench for cursor_tracker against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cursor_tracker;

    localparam int X_MAX       = 639;
    localparam int Y_MAX       = 479;
    localparam int X_CENTER    = 320;
    localparam int Y_CENTER    = 240;
    localparam int DEADZONE    = 4;
    localparam int SHIFT       = 1;
    localparam int KEY_STEP    = 1;
    localparam int DRAG_THRESH = 3;

    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [7:0] x_disp;
    logic [7:0] y_disp;
    logic [2:0] buttons;
    logic [9:0] MouseX;
    logic [9:0] MouseY;
    logic       dragging;
    logic       evt_valid;
    logic [1:0] evt_type;
    logic [9:0] evt_x;
    logic [9:0] evt_y;
    logic       evt_ready;
    logic       evt_overflow;

    cursor_tracker #(
        .POS_W(10), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_CENTER(X_CENTER), .Y_CENTER(Y_CENTER),
        .DISP_W(8), .DEADZONE(DEADZONE), .SHIFT(SHIFT), .KEY_STEP(KEY_STEP),
        .DRAG_THRESH(DRAG_THRESH)
    ) dut (
        .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode), .x_disp(x_disp),
        .y_disp(y_disp), .buttons(buttons), .MouseX(MouseX), .MouseY(MouseY),
        .dragging(dragging), .evt_valid(evt_valid), .evt_type(evt_type), .evt_x(evt_x),
        .evt_y(evt_y), .evt_ready(evt_ready), .evt_overflow(evt_overflow)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int kind;
        int x;
        int y;
    } evt_t;

    evt_t exp_q[$];
    evt_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: mode 0 = idle, 1 = button held, 2 = dragging.
    int m_x, m_y, m_mode, m_px, m_py, m_kind, m_ex, m_ey;
    bit m_lprev, m_rprev, m_valid, m_ovf;

    logic [7:0] r_kc, r_xd, r_yd;
    logic [2:0] r_btn;
    logic       r_rdy;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int motion(input logic [7:0] d);
        int v, m;
        v = int'($signed(d));
        m = (v < 0) ? -v : v;
        if (m <= DEADZONE) return 0;
        return (v < 0) ? -(m >> SHIFT) : (m >> SHIFT);
    endfunction

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_x = X_CENTER; m_y = Y_CENTER; m_mode = 0; m_px = 0; m_py = 0;
        m_kind = 0; m_ex = 0; m_ey = 0;
        m_lprev = 0; m_rprev = 0; m_valid = 0; m_ovf = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [7:0] kc, input logic [7:0] xd, input logic [7:0] yd,
                              input logic [2:0] btn, input logic rdy);
        int   dx, dy, nx, ny;
        bit   lr, lf, rr, have;
        evt_t ev;
        dx = motion(xd);
        dy = motion(yd);
        case (kc)
            8'h01:   begin dx = -KEY_STEP; dy = 0; end
            8'h02:   begin dx = KEY_STEP;  dy = 0; end
            8'h04:   begin dx = 0; dy = KEY_STEP;  end
            8'h1A:   begin dx = 0; dy = -KEY_STEP; end
            default: ;
        endcase
        nx = clamp(m_x + dx, X_MAX);
        ny = clamp(m_y + dy, Y_MAX);
        lr = btn[0] && !m_lprev;
        lf = !btn[0] && m_lprev;
        rr = btn[1] && !m_rprev;
        have = 0;
        ev = '{0, 0, 0};
        if (m_mode == 0) begin
            if (lr) begin m_mode = 1; m_px = m_x; m_py = m_y; end
        end else if (m_mode == 1) begin
            if (lf) begin have = 1; ev = '{0, m_px, m_py}; m_mode = 0; end
            else if (iabs(m_x - m_px) > DRAG_THRESH || iabs(m_y - m_py) > DRAG_THRESH) m_mode = 2;
        end else if (lf) begin
            have = 1; ev = '{1, nx, ny}; m_mode = 0;
        end
        if (rr) begin
            if (have) m_ovf = 1;
            else begin have = 1; ev = '{2, m_x, m_y}; end
        end
        if (have) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_kind = ev.kind; m_ex = ev.x; m_ey = ev.y;
                exp_q.push_back(ev);
            end else begin
                m_ovf = 1;
            end
        end else if (rdy) begin
            m_valid = 0;
        end
        m_x = nx; m_y = ny; m_lprev = btn[0]; m_rprev = btn[1];
    endtask

    task automatic check_state();
        check("MouseX", MouseX, m_x);
        check("MouseY", MouseY, m_y);
        check("dragging", dragging, (m_mode == 2) ? 1 : 0);
        check("evt_valid", evt_valid, m_valid);
        check("evt_overflow", evt_overflow, m_ovf);
        if (m_valid) begin
            check("held_type", evt_type, m_kind);
            check("held_x", evt_x, m_ex);
            check("held_y", evt_y, m_ey);
        end
    endtask

    // Called at posedge+1; drives inputs for the next edge and checks its result.
    task automatic apply(input logic [7:0] kc, input logic [7:0] xd, input logic [7:0] yd,
                         input logic [2:0] btn, input logic rdy);
        keycode = kc; x_disp = xd; y_disp = yd; buttons = btn; evt_ready = rdy;
        model_step(kc, xd, yd, btn, rdy);
        @(posedge frame_clk);
        #1;
        check_state();
    endtask

    task automatic goto_pos(input int tx, input int ty);
        int dxp, dyp, ddx, ddy;
        for (int i = 0; i < 60; i++) begin
            dxp = tx - m_x;
            dyp = ty - m_y;
            if (dxp == 0 && dyp == 0) return;
            if (iabs(dxp) >= 3 || iabs(dyp) >= 3) begin
                ddx = (iabs(dxp) >= 3) ? clamp(2 * dxp + 128, 255) - 128 : 0;
                ddy = (iabs(dyp) >= 3) ? clamp(2 * dyp + 128, 255) - 128 : 0;
                apply(8'h00, 8'(ddx), 8'(ddy), buttons, 1'b1);
            end else if (dxp != 0) begin
                apply((dxp > 0) ? 8'h02 : 8'h01, 8'h00, 8'h00, buttons, 1'b1);
            end else begin
                apply((dyp > 0) ? 8'h04 : 8'h1A, 8'h00, 8'h00, buttons, 1'b1);
            end
        end
        check("goto_reached", (m_x == tx && m_y == ty) ? 1 : 0, 1);
    endtask

    // Scoreboard monitor: a handshake is due on the next edge.
    always @(negedge frame_clk) begin
        if (!Reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL evt_unexpected: got type %0d at (%0d,%0d), required no event",
                         evt_type, evt_x, evt_y);
            end else begin
                mon_e = exp_q.pop_front();
                check("evt_type", evt_type, mon_e.kind);
                check("evt_x", evt_x, mon_e.x);
                check("evt_y", evt_y, mon_e.y);
            end
        end
    end

    initial begin
        Reset = 1'b1; keycode = 8'h00; x_disp = 8'h00; y_disp = 8'h00;
        buttons = 3'b000; evt_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge frame_clk);
        #1;
        check("rst_MouseX", MouseX, 320);
        check("rst_MouseY", MouseY, 240);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_dragging", dragging, 0);
        check("rst_overflow", evt_overflow, 0);
        Reset = 1'b0;

        // Motion, deadzone and rounding
        apply(8'h00, 8'd20, 8'h00, 3'b000, 1'b1);
        check("disp_plus20", MouseX, 330);
        apply(8'h00, 8'hF0, 8'h00, 3'b000, 1'b1);
        check("disp_minus16", MouseX, 322);
        apply(8'h00, 8'd4, 8'h00, 3'b000, 1'b1);
        check("disp_deadzone", MouseX, 322);

        // Saturation at both X limits, keyboard nudges
        repeat (6) apply(8'h00, 8'd127, 8'h00, 3'b000, 1'b1);
        check("sat_xmax", MouseX, 639);
        apply(8'h00, 8'd127, 8'h00, 3'b000, 1'b1);
        check("sat_xmax_hold", MouseX, 639);
        repeat (11) apply(8'h00, 8'h80, 8'h00, 3'b000, 1'b1);
        check("sat_xzero", MouseX, 0);
        apply(8'h01, 8'h00, 8'h00, 3'b000, 1'b1);
        check("key_left_at0", MouseX, 0);
        apply(8'h1A, 8'd100, 8'h00, 3'b000, 1'b1);
        check("key_up_y", MouseY, 239);
        check("key_up_xfrozen", MouseX, 0);

        // Click with a small wobble, held event, then a dropped right click
        goto_pos(100, 100);
        apply(8'h00, 8'h00, 8'h00, 3'b001, 1'b1);
        repeat (2) apply(8'h02, 8'h00, 8'h00, 3'b001, 1'b1);
        apply(8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
        check("click_valid", evt_valid, 1);
        check("click_type", evt_type, 0);
        check("click_x", evt_x, 100);
        check("click_y", evt_y, 100);
        apply(8'h00, 8'h00, 8'h00, 3'b010, 1'b0);
        check("ovf_set", evt_overflow, 1);
        check("ovf_held_type", evt_type, 0);
        check("ovf_held_x", evt_x, 100);
        apply(8'h00, 8'h00, 8'h00, 3'b000, 1'b1);

        // Drag and drop
        goto_pos(100, 100);
        apply(8'h00, 8'h00, 8'h00, 3'b001, 1'b1);
        apply(8'h00, 8'd20, 8'h00, 3'b001, 1'b1);
        check("drag_move_x", MouseX, 110);
        apply(8'h00, 8'h00, 8'h00, 3'b001, 1'b1);
        check("drag_on", dragging, 1);
        apply(8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
        check("drop_type", evt_type, 1);
        check("drop_x", evt_x, 110);
        check("drop_y", evt_y, 100);
        check("drop_dragging", dragging, 0);
        apply(8'h00, 8'h00, 8'h00, 3'b000, 1'b1);

        // Asynchronous reset in the middle of a drag
        apply(8'h00, 8'h00, 8'h00, 3'b001, 1'b1);
        repeat (2) apply(8'h00, 8'd20, 8'h00, 3'b001, 1'b1);
        #2;
        Reset = 1'b1; buttons = 3'b000; x_disp = 8'h00;
        #1;
        check("midrst_MouseX", MouseX, 320);
        check("midrst_MouseY", MouseY, 240);
        check("midrst_dragging", dragging, 0);
        check("midrst_valid", evt_valid, 0);
        check("midrst_overflow", evt_overflow, 0);
        model_reset();
        @(posedge frame_clk);
        #1;
        Reset = 1'b0;

        // Same-edge left release and right rise, then back-to-back load
        apply(8'h00, 8'h00, 8'h00, 3'b001, 1'b1);
        apply(8'h00, 8'h00, 8'h00, 3'b010, 1'b1);
        check("arb_type", evt_type, 0);
        check("arb_overflow", evt_overflow, 1);
        apply(8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
        apply(8'h00, 8'h00, 8'h00, 3'b010, 1'b1);
        check("b2b_valid", evt_valid, 1);
        check("b2b_type", evt_type, 2);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) goto_pos(int'($urandom_range(0, X_MAX)), int'($urandom_range(0, Y_MAX)));
            case ($urandom_range(0, 7))
                0:       r_kc = 8'h01;
                1:       r_kc = 8'h02;
                2:       r_kc = 8'h04;
                3:       r_kc = 8'h1A;
                4:       r_kc = 8'($urandom);
                default: r_kc = 8'h00;
            endcase
            r_xd  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 12) - 6);
            r_yd  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 12) - 6);
            r_btn = buttons ^ {1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                               ($urandom_range(0, 5) == 0)};
            r_rdy = ($urandom_range(0, 3) != 0);
            apply(r_kc, r_xd, r_yd, r_btn, r_rdy);
        end

        repeat (4) apply(8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cursor_tracker.md
Name: cursor_tracker

Overview:
Parametrised cursor engine for the game UI. It integrates signed mouse displacement and keyboard nudges into a saturating on-screen cursor position. It also runs a left-button click/drag state machine and a right-click detector. Pointer events go out through a one-entry valid/ready event register to the tower-placement logic.

Parameters:
POS_W, 10, width of position outputs
X_MAX, 639, rightmost legal X
Y_MAX, 479, bottommost legal Y
X_CENTER, 320, X after reset
Y_CENTER, 240, Y after reset
DISP_W, 8, width of two's-complement displacement inputs
DEADZONE, 4, displacement magnitudes <= DEADZONE are ignored
SHIFT, 1, right-shift applied to displacement magnitude
KEY_STEP, 1, pixels per frame for keyboard nudge
DRAG_THRESH, 3, pixel distance on either axis that turns a press into a drag

Ports:
Reset  in  1  asynchronous, active-high reset
frame_clk  in  1  clock, one edge per frame
keycode  in  8  current key code
x_disp  in  DISP_W  signed X displacement sample
y_disp  in  DISP_W  signed Y displacement sample
buttons  in  3  [0]=left, [1]=right, [2]=middle (unused, ignored)
MouseX  out  POS_W  cursor X
MouseY  out  POS_W  cursor Y
dragging  out  1  high while the FSM is in DRAG
evt_valid  out  1  event register holds an event
evt_type  out  2  0=left click, 1=drop, 2=right click
evt_x  out  POS_W  event X
evt_y  out  POS_W  event Y
evt_ready  in  1  consumer accepts the event
evt_overflow  out  1  sticky: an event was lost

Behaviour:
- Reset (Reset asynchronous, active-high; clock frame_clk): MouseX=X_CENTER, MouseY=Y_CENTER. FSM=IDLE. Button history cleared. evt_valid=0, evt_type=0, evt_x=0, evt_y=0, evt_overflow=0, dragging=0.
- Reset mid-drag or with a pending event discards all state; no event is emitted.
- Motion per axis:
  - Interpret disp as signed DISP_W.
  - If |d| <= DEADZONE, motion=0.
  - Otherwise motion = sign(d)*(|d|>>SHIFT), which rounds toward zero.
  - The most-negative input uses magnitude 2^(DISP_W-1).
- Keyboard override, applied after mouse motion:
  - 8'h01: X=-KEY_STEP, Y=0.
  - 8'h02: X=+KEY_STEP, Y=0.
  - 8'h04: Y=+KEY_STEP, X=0.
  - 8'h1A: Y=-KEY_STEP, X=0.
  - Any other code: no override.
- Position update on every frame_clk edge:
  - new = pos + motion, computed signed at POS_W+2 bits.
  - Saturate to [0, X_MAX] or [0, Y_MAX]; the cursor never wraps.
  - Latency: inputs sampled at edge N appear on MouseX/MouseY after edge N.
- Button edges: register buttons each edge. Rise = cur & ~prev; fall = ~cur & prev.
- FSM, IDLE -> PRESSED:
  - On left rise, latch press_x/press_y = position before this edge's update.
- FSM, PRESSED:
  - Left fall: emit left click at press_x/press_y, then go to IDLE.
  - Otherwise, if |MouseX-press_x| > DRAG_THRESH or |MouseY-press_y| > DRAG_THRESH (registered position): go to DRAG. dragging=1 from the next cycle.
  - Fall takes priority over the drag test in the same cycle.
- FSM, DRAG:
  - Left fall: emit drop at the position after this edge's update, then go to IDLE and clear dragging.
- Right click: a right rise in any state emits a right-click event at the position before update.
- Event arbitration:
  - If a left-FSM event and a right click occur on the same edge, the left event wins.
  - The losing right click sets evt_overflow.
- Event register:
  - A new event loads when evt_valid=0, or when evt_valid=1 and evt_ready=1 (back-to-back, no bubble).
  - When evt_valid=1 and evt_ready=0, the new event is dropped, evt_overflow is set, and the held event stays stable.
  - evt_valid clears on a ready handshake with no new event.
  - evt_overflow clears only on reset.

Test Plan:
- Reset, no input -> MouseX=320, MouseY=240, evt_valid=0, dragging=0; assert Reset mid-drag -> same values immediately.
- x_disp=8'd20 for 1 edge -> MouseX=330; x_disp=8'hF0 (-16) -> MouseX=322; x_disp=8'd4 -> no change.
- MouseX at 635, x_disp=8'd127 -> MouseX=639 and holds; keycode=8'h01 at X=0 -> stays 0; keycode=8'h1A at Y=240 -> 239 per frame, X frozen.
- Left press at (100,100), move 2 px, release, evt_ready=0 -> evt_valid=1, type=0, (100,100), dragging never 1; then a right rise -> evt_overflow=1, held event unchanged.
- Left press at (100,100), x_disp=8'd20 for 1 edge -> X=110, dragging=1 next cycle; release -> type=1 at (110,100), dragging=0.
- Left release and right rise on the same edge with evt_ready=1 -> one type-0 event, overflow=1; evt_valid=1 with evt_ready=1 and a new event -> new event loaded, valid stays 1.
